delay_sched: RTL and testbench

DELAY_SCHED -- requirements
Module: delay_sched

---
 rtl/delay_pkg.sv | 16 +
 rtl/rr_pick.sv | 28 ++
 rtl/delay_sched.sv | 135 +++++++++++++
 tb/tb_delay_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared definitions for delay_sched: FSM state encoding and the
// cycles-per-millisecond derivation.
package delay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Clocks slower than 1 kHz still get a one-cycle tick so the counter is legal.
    function automatic int tick_cycles(input int fclk);
        return (fclk >= 2000) ? fclk / 1000 : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: one-hot pick of the first eligible requester at or
// after ptr, wrapping around; all-zero when nothing is eligible.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     elig,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick
);

    int   idx;
    logic found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && elig[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_sched.sv
// Shared millisecond delay timer arbitrated round-robin among N_REQ requesters.
// Optional build macro DELAY_SCHED_ABORT_EN: owner dropping req mid-count aborts.
//   state    | meaning
//   ST_IDLE  | no owner; pick next eligible requester
//   ST_COUNT | owner holds timer; count ticks and ms
//   ST_DONE  | one-cycle done pulse to owner, advance pointer
module delay_sched
    import delay_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int FCLK  = 50000000,
    parameter int MS_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*MS_W-1:0] ms_in,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic                  busy
);

    localparam int TICK   = tick_cycles(FCLK);
    localparam int TICK_W = $clog2(TICK + 1);
    localparam int IDX_W  = $clog2(N_REQ);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK - 1);

    state_t              state, state_nxt;
    logic [N_REQ-1:0]    served, elig, pick;
    logic [N_REQ-1:0]    grant_nxt, done_nxt;
    logic                busy_nxt;
    logic [IDX_W-1:0]    rr_ptr, owner, owner_inc, pick_idx;
    logic [MS_W-1:0]     ms_lat, ms_cnt, ms_sel;
    logic [TICK_W-1:0]   tick_cnt;
    logic                ms_hit, abort;

    assign elig      = req & ~served;
    assign ms_hit    = (ms_cnt == ms_lat);
    assign owner_inc = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef DELAY_SCHED_ABORT_EN
    assign abort = (state == ST_COUNT) && !req[owner];
`else
    assign abort = 1'b0;
`endif

    rr_pick #(.N(N_REQ), .PTR_W(IDX_W)) u_rr_pick (
        .elig (elig),
        .ptr  (rr_ptr),
        .pick (pick)
    );

    always_comb begin
        pick_idx = '0;
        ms_sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
                ms_sel   = ms_in[i*MS_W +: MS_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (|pick) state_nxt = ST_COUNT;
            ST_COUNT: begin
                if (abort)       state_nxt = ST_IDLE;
                else if (ms_hit) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_nxt = grant;
        done_nxt  = '0;
        if (state == ST_IDLE && state_nxt == ST_COUNT) grant_nxt = pick;
        if (state_nxt == ST_IDLE)                      grant_nxt = '0;
        if (state_nxt == ST_DONE)                      done_nxt  = grant;
        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant    <= '0;
            done     <= '0;
            busy     <= 1'b0;
            served   <= '0;
            rr_ptr   <= '0;
            owner    <= '0;
            ms_lat   <= '0;
            ms_cnt   <= '0;
            tick_cnt <= '0;
        end else begin
            grant  <= grant_nxt;
            done   <= done_nxt;
            busy   <= busy_nxt;
            // done is one-hot on the owner during ST_DONE, which marks it served
            served <= (served | done) & req;
            unique case (state)
                ST_IDLE: begin
                    if (|pick) begin
                        owner    <= pick_idx;
                        ms_lat   <= ms_sel;
                        ms_cnt   <= '0;
                        tick_cnt <= '0;
                    end
                end
                ST_COUNT: begin
                    if (abort) begin
                        rr_ptr <= owner_inc;
                    end else if (!ms_hit) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            ms_cnt   <= ms_cnt + 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE:  rr_ptr <= owner_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_sched.sv
// Self-checking bench for delay_sched: timestamp-based reference model plus
// directed scenarios with hand-computed timings, then randomized traffic.
module tb_delay_sched;

    localparam int N    = 4;
    localparam int MSW  = 16;
    localparam int TICK = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*MSW-1:0] ms_in = '0;
    logic [N-1:0]     grant, done;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model: current owner, cycle its done is due, pointer, served set
    int       m_owner = -1;
    int       m_end   = 0;
    int       m_ptr   = 0;
    logic [N-1:0] m_served = '0;

    delay_sched #(.N_REQ(N), .FCLK(10000), .MS_W(MSW)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ms_in (ms_in),
        .grant (grant),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // per-cycle compare and model advance
    always @(negedge clk) begin
        logic [N-1:0] eg, ed, ns;
        int ms;
        if (!rst) begin
            check("rst_grant", 32'(grant), 0);
            check("rst_done", 32'(done), 0);
            check("rst_busy", 32'(busy), 0);
            m_owner  = -1;
            m_ptr    = 0;
            m_served = '0;
        end else begin
            eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
            ed = (m_owner >= 0 && cyc == m_end) ? eg : '0;
            check("grant", 32'(grant), 32'(eg));
            check("done", 32'(done), 32'(ed));
            check("busy", 32'(busy), (m_owner >= 0) ? 1 : 0);
            ns = m_served & req;
            if (m_owner >= 0) begin
                if (cyc == m_end) begin
                    ns      = (m_served | eg) & req;
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
`ifdef DELAY_SCHED_ABORT_EN
                else if (!req[m_owner]) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
`endif
            end else begin
                for (int k = 0; k < N; k++) begin
                    int w;
                    w = (m_ptr + k) % N;
                    if (m_owner < 0 && req[w] && !m_served[w]) begin
                        ms      = int'(ms_in[w*MSW +: MSW]);
                        m_owner = w;
                        m_end   = cyc + 1 + ((ms == 0) ? 1 : ms * TICK + 1);
                    end
                end
            end
            m_served = ns;
        end
    end

    task automatic wait_grant(output int who, output int g);
        who = -1;
        g   = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (|grant) begin
                for (int i = 0; i < N; i++) if (grant[i]) who = i;
                g = cyc;
                return;
            end
        end
        timeout("wait_grant");
    endtask

    task automatic wait_done(input int who, output int d);
        d = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (|done) begin
                d = cyc;
                check("done_owner", 32'(done), (who >= 0) ? 32'(1 << who) : 0);
                return;
            end
        end
        timeout("wait_done");
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
    endtask

    task automatic set_ms(input int i, input int v);
        ms_in[i*MSW +: MSW] = MSW'(v);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int who, g, d, prev_d, seen;
        logic [N-1:0] post_done;
        post_done = '0;

        // single request, ms=3
        do_reset();
        @(posedge clk); #1;
        set_ms(1, 3);
        req = 4'b0010;
        wait_grant(who, g);
        check("single_owner", who, 1);
        wait_done(1, d);
        check("single_lat", d - g, 31);
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        check("single_busy_drop", 32'(busy), 0);
        check("single_grant_drop", 32'(grant), 0);

        // zero delay
        @(posedge clk); #1;
        set_ms(2, 0);
        req = 4'b0100;
        wait_grant(who, g);
        check("zero_owner", who, 2);
        wait_done(2, d);
        check("zero_lat", d - g, 1);
        @(posedge clk); #1 req = '0;

        // contention, all ms=1
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_ms(i, 1);
        req = 4'b1111;
        prev_d = 0;
        for (int k = 0; k < N; k++) begin
            wait_grant(who, g);
            check("cont_owner", who, k);
            wait_done(who, d);
            check("cont_lat", d - g, 11);
            if (k > 0) check("cont_gap", g - prev_d, 2);
            prev_d = d;
            @(posedge clk); #1;
            if (who >= 0) req[who] = 1'b0;
        end

        // hold after done: req[0] stays high, req[3] served next
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_ms(i, 0);
        req = 4'b1001;
        wait_grant(who, g);
        check("hold_first", who, 0);
        wait_done(0, d);
        wait_grant(who, g);
        check("hold_second", who, 3);
        wait_done(3, d);
        @(posedge clk); #1 req[3] = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (|grant) seen++;
        end
        check("hold_no_regrant", seen, 0);
        @(posedge clk); #1 req[0] = 1'b0;
        @(posedge clk); #1 req[0] = 1'b1;
        wait_grant(who, g);
        check("hold_regrant", who, 0);
        wait_done(0, d);
        @(posedge clk); #1 req = '0;

        // drop req mid-count
        do_reset();
        @(posedge clk); #1;
        set_ms(1, 2);
        req = 4'b0010;
        wait_grant(who, g);
        repeat (5) @(posedge clk);
        #1 req = '0;
        @(negedge clk);
        @(negedge clk);
`ifdef DELAY_SCHED_ABORT_EN
        check("abort_grant", 32'(grant), 0);
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (|done) seen++;
        end
        check("abort_no_done", seen, 0);
`else
        check("noabort_grant", 32'(grant), 32'b0010);
        wait_done(1, d);
        check("noabort_lat", d - g, 21);
`endif

        // reset mid-count, pending requests re-granted from pointer 0
        do_reset();
        @(posedge clk); #1;
        set_ms(1, 0);
        req = 4'b0010;
        wait_grant(who, g);
        wait_done(1, d);
        @(posedge clk); #1 req = '0;
        repeat (2) @(posedge clk);
        #1;
        set_ms(2, 2);
        req = 4'b0110;
        wait_grant(who, g);
        check("rst_pre_owner", who, 2);
        repeat (7) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_grant", 32'(grant), 0);
        check("async_done", 32'(done), 0);
        check("async_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        wait_grant(who, g);
        check("rst_regrant", who, 1);
        wait_done(1, d);
        @(posedge clk); #1 req = '0;

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                set_ms(i, int'($urandom_range(0, 3)));
                if (!req[i]) begin
                    post_done[i] = 1'b0;
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
                end else if (done[i]) begin
                    post_done[i] = 1'b1;
                end else if (post_done[i]) begin
                    if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
                end else if (grant[i] && $urandom_range(0, 59) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        @(posedge clk); #1 req = '0;
        repeat (40) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
